quad_step_decoder: RTL and testbench



---
 rtl/quad_step_decoder.sv | 121 ++++++++++++
 tb/tb_quad_step_decoder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronizes and debounces two phase inputs, decodes the
// Gray-code sequence and emits one-cycle enable/up_down commands every DIVIDE quarter-steps.
module quad_step_decoder #(
    parameter int FILTER_CYCLES = 4,
    parameter int DIVIDE        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic quad_a,
    input  logic quad_b,
    output logic enable,
    output logic up_down,
    output logic err
);

    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter
        $error("FILTER_CYCLES must be in 1..15");
    end
    if (DIVIDE != 1 && DIVIDE != 2 && DIVIDE != 4) begin : g_bad_divide
        $error("DIVIDE must be 1, 2 or 4");
    end

    localparam logic        [3:0] FC    = 4'(FILTER_CYCLES);
    localparam logic signed [3:0] DIV_P = 4'(DIVIDE);
    localparam logic signed [3:0] DIV_N = -DIV_P;

    logic        [1:0] r_s1;
    logic        [1:0] r_s2;
    logic        [1:0] r_sv;
    logic        [3:0] r_stable;
    logic        [1:0] r_filt;
    logic              r_init;
    logic signed [3:0] r_acc;
    logic              r_enable;
    logic              r_up_down;
    logic              r_err;

    logic              w_accept;
    logic              w_fwd;
    logic              w_rev;
    logic signed [3:0] w_acc_inc;
    logic signed [3:0] w_acc_dec;

    always_comb begin
        w_accept  = (r_stable == FC) && (!r_init || (r_s2 != r_filt));
        w_fwd     = 1'b0;
        w_rev     = 1'b0;
        // {previous accepted phase, new phase}; forward order is 00->01->11->10->00
        case ({r_filt, r_s2})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: w_fwd = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: w_rev = 1'b1;
            default: ;
        endcase
        w_acc_inc = r_acc + 4'sd1;
        w_acc_dec = r_acc - 4'sd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_sv      <= '0;
            r_stable  <= '0;
            r_filt    <= '0;
            r_init    <= 1'b0;
            r_acc     <= '0;
            r_enable  <= 1'b0;
            r_up_down <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_s1 <= {quad_a, quad_b};
            r_s2 <= r_s1;
            r_sv <= {r_sv[0], 1'b1};

            // r_sv marks which sync stages hold real samples, so the cleared
            // post-reset contents of s2 never count as a held phase value.
            if (!r_sv[0]) begin
                r_stable <= '0;
            end else if (!r_sv[1] || (r_s1 != r_s2)) begin
                r_stable <= 4'd1;
            end else if (r_stable != FC) begin
                r_stable <= r_stable + 4'd1;
            end

            r_enable  <= 1'b0;
            r_up_down <= 1'b0;
            r_err     <= 1'b0;

            if (w_accept) begin
                r_filt <= r_s2;
                r_init <= 1'b1;
                if (r_init) begin
                    if (w_fwd) begin
                        if (w_acc_inc == DIV_P) begin
                            r_enable  <= 1'b1;
                            r_up_down <= 1'b1;
                            r_acc     <= '0;
                        end else begin
                            r_acc <= w_acc_inc;
                        end
                    end else if (w_rev) begin
                        if (w_acc_dec == DIV_N) begin
                            r_enable <= 1'b1;
                            r_acc    <= '0;
                        end else begin
                            r_acc <= w_acc_dec;
                        end
                    end else begin
                        r_err <= 1'b1;
                        r_acc <= '0;
                    end
                end
            end
        end
    end

    assign enable  = r_enable;
    assign up_down = r_up_down;
    assign err     = r_err;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: two instances (default and FILTER_CYCLES=2/DIVIDE=1) checked
// every cycle against a sample-history reference model, plus scenario-specific counts.
module tb_quad_step_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic quad_a = 1'b0;
    logic quad_b = 1'b0;
    logic en0, ud0, er0, en1, ud1, er1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] cur_ab = 2'b00;

    always #5 clk = ~clk;

    quad_step_decoder #(.FILTER_CYCLES(4), .DIVIDE(4)) dut0 (
        .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b),
        .enable(en0), .up_down(ud0), .err(er0)
    );

    quad_step_decoder #(.FILTER_CYCLES(2), .DIVIDE(1)) dut1 (
        .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b),
        .enable(en1), .up_down(ud1), .err(er1)
    );

    // Reference model: history of samples taken since reset; a phase is accepted once
    // FILTER_CYCLES consecutive samples agree, two sample periods behind the newest one.
    int         MF [2] = '{4, 2};
    int         MD [2] = '{4, 1};
    logic [1:0] hist [0:19];
    int         nsamp;
    logic [1:0] m_filt [2];
    int         m_acc  [2];
    logic       m_init [2];
    logic       m_en   [2];
    logic       m_ud   [2];
    logic       m_err  [2];

    function automatic int pos(input logic [1:0] v);
        return {30'd0, v[1], v[1] ^ v[0]};
    endfunction

    function automatic logic [1:0] phase_of(input int p);
        logic [1:0] b;
        b = 2'(p % 4);
        return {b[1], b[1] ^ b[0]};
    endfunction

    function automatic logic [5:0] mexp();
        return {m_en[0], m_ud[0], m_err[0], m_en[1], m_ud[1], m_err[1]};
    endfunction

    task automatic model_step(input logic [1:0] ab, input logic r);
        logic       same;
        logic [1:0] v;
        int         d;
        for (int i = 0; i < 2; i++) begin
            m_en[i] = 1'b0; m_ud[i] = 1'b0; m_err[i] = 1'b0;
        end
        if (r) begin
            nsamp = 0;
            for (int i = 0; i < 2; i++) begin
                m_filt[i] = 2'b00; m_acc[i] = 0; m_init[i] = 1'b0;
            end
        end else begin
            for (int j = 19; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = ab;
            if (nsamp < 1000) nsamp++;
            for (int i = 0; i < 2; i++) begin
                if (nsamp >= MF[i] + 2) begin
                    same = 1'b1;
                    for (int j = 3; j <= MF[i] + 1; j++) if (hist[j] != hist[2]) same = 1'b0;
                    v = hist[2];
                    if (same && !m_init[i]) begin
                        m_filt[i] = v;
                        m_init[i] = 1'b1;
                    end else if (same && v != m_filt[i]) begin
                        d = (pos(v) - pos(m_filt[i]) + 4) % 4;
                        m_filt[i] = v;
                        if (d == 1) begin
                            m_acc[i]++;
                            if (m_acc[i] == MD[i]) begin m_en[i] = 1'b1; m_ud[i] = 1'b1; m_acc[i] = 0; end
                        end else if (d == 3) begin
                            m_acc[i]--;
                            if (m_acc[i] == -MD[i]) begin m_en[i] = 1'b1; m_acc[i] = 0; end
                        end else begin
                            m_err[i] = 1'b1;
                            m_acc[i] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic [1:0] ab, input logic r);
        quad_a = ab[1];
        quad_b = ab[0];
        rst    = r;
        cur_ab = ab;
        @(posedge clk);
        model_step(ab, r);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n_out;
        n_out = 0;
        cycle(2'b11, 1'b1);
        cycle(2'b11, 1'b1);
        n_checks++;
        if ({en0, ud0, er0, en1, ud1, er1} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 000000", {en0, ud0, er0, en1, ud1, er1});
        end
        for (int c = 0; c < 20; c++) begin
            cycle(2'b11, 1'b0);
            n_checks++;
            if ({en0, ud0, er0, en1, ud1, er1} !== mexp()) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %b, want %b", c, {en0, ud0, er0, en1, ud1, er1}, mexp());
            end
            n_out += int'(en0) + int'(er0) + int'(en1) + int'(er1);
        end
        n_checks++;
        if (n_out !== 0) begin
            n_fail++;
            $display("FAIL reset_hold_pulses: got %0d pulses, want 0", n_out);
        end
    endtask

    task automatic test_forward();
        logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        int n_up, n_other, en_idx;
        n_up = 0; n_other = 0; en_idx = -1;
        for (int c = 0; c < 10; c++) begin
            cycle(2'b00, 1'b0);
            n_checks++;
            if ({en0, ud0, er0, en1, ud1, er1} !== mexp()) begin
                n_fail++;
                $display("FAIL fwd_pre cyc %0d: got %b, want %b", c, {en0, ud0, er0, en1, ud1, er1}, mexp());
            end
        end
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 10; c++) begin
                cycle(seq[p], 1'b0);
                n_checks++;
                if ({en0, ud0, er0, en1, ud1, er1} !== mexp()) begin
                    n_fail++;
                    $display("FAIL fwd p%0d cyc %0d: got %b, want %b", p, c, {en0, ud0, er0, en1, ud1, er1}, mexp());
                end
                if (en0 && ud0 && p == 3) begin n_up++; en_idx = c; end
                else if (en0 || er0) n_other++;
            end
        end
        n_checks++;
        if (n_up !== 1 || n_other !== 0) begin
            n_fail++;
            $display("FAIL fwd_count: got up=%0d other=%0d, want up=1 other=0", n_up, n_other);
        end
        n_checks++;
        if (en_idx !== 5) begin
            n_fail++;
            $display("FAIL fwd_latency: got %0d cycles, want 5", en_idx);
        end
    endtask

    task automatic test_reverse();
        logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        int n_en, n_good;
        n_en = 0; n_good = 0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 6; c++) begin
                cycle(seq[p], 1'b0);
                n_checks++;
                if ({en0, ud0, er0, en1, ud1, er1} !== mexp()) begin
                    n_fail++;
                    $display("FAIL rev p%0d cyc %0d: got %b, want %b", p, c, {en0, ud0, er0, en1, ud1, er1}, mexp());
                end
                if (en1) n_en++;
                if (en1 && !ud1 && c == 3) n_good++;
            end
        end
        n_checks++;
        if (n_en !== 4 || n_good !== 4) begin
            n_fail++;
            $display("FAIL rev_div1: got en=%0d timed_down=%0d, want 4 and 4", n_en, n_good);
        end
    endtask

    task automatic test_glitch();
        int lens [2] = '{3, 4};
        int n_out;
        for (int g = 0; g < 2; g++) begin
            n_out = 0;
            for (int c = 0; c < 8 + lens[g] + 8; c++) begin
                cycle((c >= 8 && c < 8 + lens[g]) ? 2'b10 : 2'b00, 1'b0);
                n_checks++;
                if ({en0, ud0, er0, en1, ud1, er1} !== mexp()) begin
                    n_fail++;
                    $display("FAIL glitch len %0d cyc %0d: got %b, want %b", lens[g], c, {en0, ud0, er0, en1, ud1, er1}, mexp());
                end
                n_out += int'(en0) + int'(er0);
            end
            n_checks++;
            if (n_out !== 0) begin
                n_fail++;
                $display("FAIL glitch_pulses len %0d: got %0d, want 0", lens[g], n_out);
            end
        end
    endtask

    task automatic test_illegal();
        logic [1:0] seq [5] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
        int n_err, n_en_bad, n_up;
        n_err = 0; n_en_bad = 0; n_up = 0;
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 10; c++) begin
                cycle(seq[p], 1'b0);
                n_checks++;
                if ({en0, ud0, er0, en1, ud1, er1} !== mexp()) begin
                    n_fail++;
                    $display("FAIL illegal p%0d cyc %0d: got %b, want %b", p, c, {en0, ud0, er0, en1, ud1, er1}, mexp());
                end
                if (p == 0) begin
                    n_err += int'(er0);
                    n_en_bad += int'(en0);
                end else begin
                    n_err += int'(er0);
                    if (en0 && ud0) n_up++;
                    else if (en0) n_en_bad++;
                end
            end
        end
        n_checks++;
        if (n_err !== 1 || n_en_bad !== 0) begin
            n_fail++;
            $display("FAIL illegal_err: got err=%0d stray_en=%0d, want 1 and 0", n_err, n_en_bad);
        end
        n_checks++;
        if (n_up !== 1) begin
            n_fail++;
            $display("FAIL illegal_recover: got %0d up commands, want 1", n_up);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] seq [3] = '{2'b10, 2'b00, 2'b01};
        int n_out;
        n_out = 0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 10; c++) begin
                cycle(seq[p], 1'b0);
                n_checks++;
                if ({en0, ud0, er0, en1, ud1, er1} !== mexp()) begin
                    n_fail++;
                    $display("FAIL rstmid p%0d cyc %0d: got %b, want %b", p, c, {en0, ud0, er0, en1, ud1, er1}, mexp());
                end
                n_out += int'(en0) + int'(er0);
            end
        end
        cycle(2'b01, 1'b1);
        n_checks++;
        if ({en0, ud0, er0} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_reset: got %b, want 000", {en0, ud0, er0});
        end
        for (int c = 0; c < 18; c++) begin
            cycle((c < 8) ? 2'b01 : 2'b11, 1'b0);
            n_checks++;
            if ({en0, ud0, er0, en1, ud1, er1} !== mexp()) begin
                n_fail++;
                $display("FAIL rstmid_post cyc %0d: got %b, want %b", c, {en0, ud0, er0, en1, ud1, er1}, mexp());
            end
            n_out += int'(en0) + int'(er0);
        end
        n_checks++;
        if (n_out !== 0) begin
            n_fail++;
            $display("FAIL rstmid_pulses: got %0d, want 0", n_out);
        end
    endtask

    task automatic test_random();
        logic [1:0] base, nxt;
        int kind, len, glen;
        for (int s = 0; s < 200; s++) begin
            base = cur_ab;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 12);
            glen = 0;
            if (kind < 7) nxt = phase_of(pos(base) + (($urandom_range(0, 1) == 1) ? 1 : 3));
            else if (kind == 7) nxt = ~base;
            else begin
                nxt  = base ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
                glen = $urandom_range(1, 5);
            end
            if (s == 100) cycle(base, 1'b1);
            for (int c = 0; c < len + glen; c++) begin
                cycle((glen != 0 && c >= glen) ? base : nxt, 1'b0);
                n_checks++;
                if ({en0, ud0, er0, en1, ud1, er1} !== mexp()) begin
                    n_fail++;
                    $display("FAIL random seg %0d cyc %0d: got %b, want %b", s, c, {en0, ud0, er0, en1, ud1, er1}, mexp());
                end
                n_checks++;
                if ((en0 && er0) || (en1 && er1) || (ud0 && !en0) || (ud1 && !en1)) begin
                    n_fail++;
                    $display("FAIL random_exclusive seg %0d: got %b, want no en+err and no ud without en", s, {en0, ud0, er0, en1, ud1, er1});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
